// File: rtl/lsq_dcache_sched_pkg.sv
// Shared definitions for the LSU data-cache port scheduler.
// Holds the scheduler state encoding, the default store-starvation limit
// and a helper that sizes the starvation counter.
package lsq_dcache_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_REQ,
    S_LD_WAIT,
    S_FWD,
    S_ST_REQ,
    S_ST_WAIT,
    S_DRAIN
  } sched_state_t;

  localparam int unsigned STARVE_MAX_DEF = 4;

  // Bits needed to count 0..max inclusive (at least one bit).
  function automatic int unsigned ctr_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/lsq_starve_ctr.sv
// Saturating counter of consecutive load grants while a store waits.
// Ports: clk, rst (async, active-high), inc (count one load grant),
// clr (store granted, restart), at_max (counter has reached MAX).
module lsq_starve_ctr
  import lsq_dcache_sched_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = ctr_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/lsq_dcache_sched.sv
// Shares the single data-cache port between load issue and committed-store
// drain. One memory operation is in flight at a time. Loads that hit an
// older store are served from the SDQ without touching the cache.
// Ports:
//   i_ld_*  / o_ld_ready   load candidate from the LAQ and its accept
//   i_fwd_* / o_sdq_raddr  store-to-load forwarding hit and SDQ read port
//   i_st_*  / o_st_ready   committed store at SAQ head and its accept
//   o_dc_* / i_dc_*        cache request/grant/response
//   i_kill                 pipeline flush of the in-flight load
//   o_wb_*                 registered one-cycle load writeback
//   o_st_done / o_st_saq   registered one-cycle store completion
//   o_busy                 scheduler not idle
module lsq_dcache_sched
  import lsq_dcache_sched_pkg::*;
#(
  parameter int unsigned WIDTH_SAQ  = 2,
  parameter int unsigned WIDTH_LAQ  = 2,
  parameter int unsigned WIDTH_REG  = 7,
  parameter int unsigned WIDTH_ADDR = 32,
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [WIDTH_ADDR-1:0] i_ld_addr,
  input  logic [WIDTH_REG-1:0]  i_ld_rd,
  input  logic [WIDTH_LAQ-1:0]  i_ld_idx,
  input  logic                  i_fwd_hit,
  input  logic [WIDTH_SAQ-1:0]  i_fwd_sdq,
  input  logic                  i_st_valid,
  output logic                  o_st_ready,
  input  logic [WIDTH_ADDR-1:0] i_st_addr,
  input  logic [WIDTH_DATA-1:0] i_st_data,
  input  logic [WIDTH_SAQ-1:0]  i_st_idx,
  input  logic                  i_saq_full,
  output logic [WIDTH_SAQ-1:0]  o_sdq_raddr,
  input  logic [WIDTH_DATA-1:0] i_sdq_rdata,
  output logic                  o_dc_req,
  output logic                  o_dc_we,
  output logic [WIDTH_ADDR-1:0] o_dc_addr,
  output logic [WIDTH_DATA-1:0] o_dc_wdata,
  input  logic                  i_dc_gnt,
  input  logic                  i_dc_rvalid,
  input  logic [WIDTH_DATA-1:0] i_dc_rdata,
  input  logic                  i_kill,
  output logic                  o_wb_valid,
  output logic [WIDTH_REG-1:0]  o_wb_rd,
  output logic [WIDTH_DATA-1:0] o_wb_data,
  output logic [WIDTH_LAQ-1:0]  o_wb_laq,
  output logic                  o_st_done,
  output logic [WIDTH_SAQ-1:0]  o_st_saq,
  output logic                  o_busy
);

  sched_state_t          state;
  logic                  at_max;
  logic                  st_win;
  logic                  ld_win;
  logic                  st_acc;
  logic                  ld_acc;
  logic [WIDTH_ADDR-1:0] addr_q;
  logic [WIDTH_DATA-1:0] data_q;
  logic [WIDTH_REG-1:0]  rd_q;
  logic [WIDTH_LAQ-1:0]  laq_q;
  logic [WIDTH_SAQ-1:0]  saq_q;
  logic [WIDTH_SAQ-1:0]  sdq_q;
  logic                  dc_req_q;
  logic                  dc_we_q;

  // Stores win when the SAQ is full, when loads have starved them long
  // enough, or when no load competes.
  always_comb begin
    st_win = i_st_valid && (i_saq_full || at_max || !i_ld_valid);
    ld_win = !st_win && i_ld_valid && !i_kill;
  end

  // Accepts are gated by rst so ready stays low while reset is held.
  assign st_acc     = (state == S_IDLE) && !rst && st_win;
  assign ld_acc     = (state == S_IDLE) && !rst && ld_win;
  assign o_st_ready = st_acc;
  assign o_ld_ready = ld_acc;
  assign o_busy     = (state != S_IDLE);

  // The SDQ read is synchronous, so the address must be presented in the
  // accept cycle for data to arrive during FWD.
  assign o_sdq_raddr = (ld_acc && i_fwd_hit) ? i_fwd_sdq : sdq_q;

  assign o_dc_req   = dc_req_q;
  assign o_dc_we    = dc_we_q;
  assign o_dc_addr  = addr_q;
  assign o_dc_wdata = data_q;

  lsq_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (ld_acc && i_st_valid),
    .clr   (st_acc),
    .at_max(at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      laq_q      <= '0;
      saq_q      <= '0;
      sdq_q      <= '0;
      dc_req_q   <= 1'b0;
      dc_we_q    <= 1'b0;
      o_wb_valid <= 1'b0;
      o_wb_rd    <= '0;
      o_wb_data  <= '0;
      o_wb_laq   <= '0;
      o_st_done  <= 1'b0;
      o_st_saq   <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      o_st_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st_acc) begin
            addr_q   <= i_st_addr;
            data_q   <= i_st_data;
            saq_q    <= i_st_idx;
            dc_req_q <= 1'b1;
            dc_we_q  <= 1'b1;
            state    <= S_ST_REQ;
          end else if (ld_acc) begin
            addr_q <= i_ld_addr;
            rd_q   <= i_ld_rd;
            laq_q  <= i_ld_idx;
            if (i_fwd_hit) begin
              sdq_q <= i_fwd_sdq;
              state <= S_FWD;
            end else begin
              dc_req_q <= 1'b1;
              dc_we_q  <= 1'b0;
              state    <= S_LD_REQ;
            end
          end
        end
        S_LD_REQ: begin
          // A kill that coincides with the grant still owes the cache a
          // response, so it must be drained.
          if (i_kill) begin
            dc_req_q <= 1'b0;
            state    <= i_dc_gnt ? S_DRAIN : S_IDLE;
          end else if (i_dc_gnt) begin
            dc_req_q <= 1'b0;
            state    <= S_LD_WAIT;
          end
        end
        S_LD_WAIT: begin
          if (i_dc_rvalid) begin
            if (!i_kill) begin
              o_wb_valid <= 1'b1;
              o_wb_data  <= i_dc_rdata;
              o_wb_rd    <= rd_q;
              o_wb_laq   <= laq_q;
            end
            state <= S_IDLE;
          end else if (i_kill) begin
            state <= S_DRAIN;
          end
        end
        S_FWD: begin
          if (!i_kill) begin
            o_wb_valid <= 1'b1;
            o_wb_data  <= i_sdq_rdata;
            o_wb_rd    <= rd_q;
            o_wb_laq   <= laq_q;
          end
          state <= S_IDLE;
        end
        S_ST_REQ: begin
          if (i_dc_gnt) begin
            dc_req_q <= 1'b0;
            dc_we_q  <= 1'b0;
            state    <= S_ST_WAIT;
          end
        end
        S_ST_WAIT: begin
          if (i_dc_rvalid) begin
            o_st_done <= 1'b1;
            o_st_saq  <= saq_q;
            state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (i_dc_rvalid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_dcache_sched.sv
// Self-checking bench for lsq_dcache_sched: a cache model and an SDQ model
// respond to the DUT; expected writebacks and store completions are queued
// at accept time and compared when the DUT reports them.
module tb_lsq_dcache_sched;

  localparam int unsigned WS = 2, WL = 2, WR = 7, WA = 32, WD = 32, SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ld_valid, o_ld_ready;
  logic [WA-1:0] i_ld_addr;
  logic [WR-1:0] i_ld_rd;
  logic [WL-1:0] i_ld_idx;
  logic          i_fwd_hit;
  logic [WS-1:0] i_fwd_sdq;
  logic          i_st_valid, o_st_ready;
  logic [WA-1:0] i_st_addr;
  logic [WD-1:0] i_st_data;
  logic [WS-1:0] i_st_idx;
  logic          i_saq_full;
  logic [WS-1:0] o_sdq_raddr;
  logic [WD-1:0] i_sdq_rdata;
  logic          o_dc_req, o_dc_we;
  logic [WA-1:0] o_dc_addr;
  logic [WD-1:0] o_dc_wdata;
  logic          i_dc_gnt, i_dc_rvalid;
  logic [WD-1:0] i_dc_rdata;
  logic          i_kill;
  logic          o_wb_valid;
  logic [WR-1:0] o_wb_rd;
  logic [WD-1:0] o_wb_data;
  logic [WL-1:0] o_wb_laq;
  logic          o_st_done;
  logic [WS-1:0] o_st_saq;
  logic          o_busy;
  logic          gnt_en;

  assign i_dc_gnt = o_dc_req & gnt_en;

  lsq_dcache_sched #(
    .WIDTH_SAQ (WS),
    .WIDTH_LAQ (WL),
    .WIDTH_REG (WR),
    .WIDTH_ADDR(WA),
    .WIDTH_DATA(WD),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_addr(i_ld_addr),
    .i_ld_rd(i_ld_rd), .i_ld_idx(i_ld_idx), .i_fwd_hit(i_fwd_hit), .i_fwd_sdq(i_fwd_sdq),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_addr(i_st_addr),
    .i_st_data(i_st_data), .i_st_idx(i_st_idx), .i_saq_full(i_saq_full),
    .o_sdq_raddr(o_sdq_raddr), .i_sdq_rdata(i_sdq_rdata),
    .o_dc_req(o_dc_req), .o_dc_we(o_dc_we), .o_dc_addr(o_dc_addr), .o_dc_wdata(o_dc_wdata),
    .i_dc_gnt(i_dc_gnt), .i_dc_rvalid(i_dc_rvalid), .i_dc_rdata(i_dc_rdata),
    .i_kill(i_kill),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_wb_laq(o_wb_laq),
    .o_st_done(o_st_done), .o_st_saq(o_st_saq), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WR-1:0] rd;
    logic [WL-1:0] laq;
    logic [WD-1:0] data;
  } wb_exp_t;

  wb_exp_t       wb_q[$];
  logic [WS-1:0] st_q[$];
  int            n_checks = 0, n_fail = 0;
  int            ld_acc_cnt = 0, st_acc_cnt = 0, wb_cnt = 0, st_done_cnt = 0, req_seen = 0;
  int            grant_n = 0;
  logic [31:0]   grant_bits = '0;
  time           acc_time = 0, wb_time = 0, rv_time = 0;
  logic [WD-1:0] cmem [logic [WA-1:0]];
  logic [WD-1:0] sdq_mem [4];
  int unsigned   rsp_lat = 2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WD-1:0] cache_read(input logic [WA-1:0] a);
    return cmem.exists(a) ? cmem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cache: records a granted request mid-cycle, answers rsp_lat cycles
  // after the grant cycle with a one-cycle rvalid.
  initial begin : cache_model
    logic          fire;
    logic [WD-1:0] rsp;
    int unsigned   cnt;
    i_dc_rvalid = 1'b0;
    i_dc_rdata  = '0;
    rsp         = '0;
    cnt         = 0;
    forever begin
      @(negedge clk);
      fire = o_dc_req && i_dc_gnt && !rst;
      if (fire) begin
        if (o_dc_we) begin
          cmem[o_dc_addr] = o_dc_wdata;
          rsp = '0;
        end else begin
          rsp = cache_read(o_dc_addr);
        end
      end
      @(posedge clk);
      #1;
      i_dc_rvalid = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            i_dc_rvalid = 1'b1;
            i_dc_rdata  = rsp;
            rv_time     = $time;
          end
        end
        if (fire) cnt = rsp_lat - 1;
      end
    end
  end

  // SDQ: synchronous read, data one cycle after the address.
  initial begin : sdq_model
    logic [WS-1:0] ra;
    i_sdq_rdata = '0;
    forever begin
      @(negedge clk);
      ra = o_sdq_raddr;
      @(posedge clk);
      #1;
      i_sdq_rdata = sdq_mem[ra];
    end
  end

  // Scoreboard: push expectations on accept, pop on writeback/completion.
  initial begin : monitor
    wb_exp_t       e;
    logic [WS-1:0] s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_dc_req) req_seen++;
        if (o_ld_ready && i_ld_valid) begin
          check("ld_acc_excl", {o_busy, o_st_ready}, 2'b00);
          e.rd   = i_ld_rd;
          e.laq  = i_ld_idx;
          e.data = i_fwd_hit ? sdq_mem[i_fwd_sdq] : cache_read(i_ld_addr);
          if (i_fwd_hit) check("fwd_raddr", o_sdq_raddr, i_fwd_sdq);
          wb_q.push_back(e);
          ld_acc_cnt++;
          acc_time   = $time;
          grant_bits = {grant_bits[30:0], 1'b0};
          grant_n++;
        end
        if (o_st_ready && i_st_valid) begin
          check("st_acc_idle", o_busy, 1'b0);
          st_q.push_back(i_st_idx);
          st_acc_cnt++;
          grant_bits = {grant_bits[30:0], 1'b1};
          grant_n++;
        end
        if (o_wb_valid) begin
          if (wb_q.size() == 0) begin
            check("wb_unexpected", o_wb_valid, 1'b0);
          end else begin
            e = wb_q.pop_front();
            check("wb_rd", o_wb_rd, e.rd);
            check("wb_laq", o_wb_laq, e.laq);
            check("wb_data", o_wb_data, e.data);
          end
          wb_cnt++;
          wb_time = $time;
        end
        if (o_st_done) begin
          if (st_q.size() == 0) begin
            check("st_done_unexpected", o_st_done, 1'b0);
          end else begin
            s = st_q.pop_front();
            check("st_saq", o_st_saq, s);
          end
          st_done_cnt++;
        end
      end
    end
  end

  task automatic wait_acc(input string tag, input bit is_st);
    int prev = is_st ? st_acc_cnt : ld_acc_cnt;
    int cur  = prev;
    for (int c = 0; c < 50 && cur == prev; c++) begin
      step();
      cur = is_st ? st_acc_cnt : ld_acc_cnt;
    end
    check(tag, cur, prev + 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 100 && o_busy; c++) step();
    check(tag, o_busy, 1'b0);
  endtask

  task automatic set_load(input logic [WA-1:0] a, input int rd, input int idx);
    i_ld_addr = a;
    i_ld_rd   = WR'(rd);
    i_ld_idx  = WL'(idx);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lprev, sprev, lk, sk, n0, w0;
    rst = 1'b1;
    i_ld_valid = 1'b0; i_fwd_hit = 1'b0; i_fwd_sdq = '0;
    set_load('0, 0, 0);
    i_st_valid = 1'b0; i_st_addr = '0; i_st_data = '0; i_st_idx = '0;
    i_saq_full = 1'b0; i_kill = 1'b0; gnt_en = 1'b1;
    sdq_mem[0] = 32'h1111_0000; sdq_mem[1] = 32'h2222_0001;
    sdq_mem[2] = 32'h3333_0002; sdq_mem[3] = 32'h0000_1234;
    cmem[32'h100] = 32'hDEAD_BEEF;
    cmem[32'h180] = 32'h0000_00AA;
    repeat (3) step();
    check("reset_ctrl", {o_busy, o_dc_req, o_dc_we, o_wb_valid, o_st_done, o_ld_ready, o_st_ready}, '0);
    check("reset_dc", {o_dc_addr, o_dc_wdata}, '0);
    check("reset_regs", {o_wb_rd, o_wb_laq, o_sdq_raddr, o_st_saq}, '0);
    check("reset_wbdata", o_wb_data, '0);
    rst = 1'b0;
    step();

    // 1: plain load through the cache
    set_load(32'h100, 5, 2);
    i_ld_valid = 1'b1;
    wait_acc("t1_accept", 1'b0);
    i_ld_valid = 1'b0;
    wait_idle("t1_idle");
    step();
    check("t1_wb_count", wb_cnt, 1);

    // 2: forwarded load, served from SDQ entry 3
    req_seen = 0;
    set_load(32'h140, 6, 1);
    i_fwd_hit = 1'b1; i_fwd_sdq = 2'd3; i_ld_valid = 1'b1;
    wait_acc("t2_accept", 1'b0);
    i_ld_valid = 1'b0; i_fwd_hit = 1'b0;
    wait_idle("t2_idle");
    step();
    check("t2_wb_count", wb_cnt, 2);
    check("t2_no_dc_req", req_seen, 0);
    check("t2_latency", wb_time - acc_time, 20);

    // 3: continuous loads and stores; starvation limit then SAQ full
    lk = 0; sk = 0;
    set_load(32'h200, 10, 0);
    i_st_addr = 32'h800; i_st_data = 32'hC0DE_0000; i_st_idx = '0;
    lprev = ld_acc_cnt; sprev = st_acc_cnt;
    grant_n = 0; grant_bits = '0;
    i_ld_valid = 1'b1; i_st_valid = 1'b1;
    for (int c = 0; c < 400 && grant_n < 10; c++) begin
      step();
      if (ld_acc_cnt != lprev) begin
        lprev = ld_acc_cnt; lk++;
        set_load(32'h200 + 32'(lk * 4), 10 + lk, lk);
      end
      if (st_acc_cnt != sprev) begin
        sprev = st_acc_cnt; sk++;
        i_st_addr = 32'h800 + 32'(sk * 4);
        i_st_data = 32'hC0DE_0000 + 32'(sk);
        i_st_idx  = WS'(sk);
      end
    end
    check("t3_order", grant_bits[9:0], 10'b0000100001);
    i_saq_full = 1'b1;
    n0 = grant_n;
    for (int c = 0; c < 50 && grant_n == n0; c++) step();
    check("t3_full_grant_count", grant_n, 11);
    check("t3_full_is_store", grant_bits[0], 1'b1);
    i_ld_valid = 1'b0; i_st_valid = 1'b0; i_saq_full = 1'b0;
    wait_idle("t3_idle");
    step();

    // 4: kill in LD_WAIT, response 3 cycles later must be drained
    rsp_lat = 4;
    w0 = wb_cnt;
    set_load(32'h180, 12, 3);
    i_ld_valid = 1'b1;
    wait_acc("t4_accept", 1'b0);
    set_load(32'h1C0, 13, 0);
    step();
    i_kill = 1'b1;
    wb_q.delete();
    step();
    i_kill = 1'b0;
    wait_acc("t4_next_accept", 1'b0);
    i_ld_valid = 1'b0;
    check("t4_accept_after_drain", acc_time > rv_time, 1'b1);
    wait_idle("t4_idle");
    step();
    check("t4_wb_count", wb_cnt, w0 + 1);
    rsp_lat = 2;

    // 4b: kill in LD_REQ before grant drops the request
    gnt_en = 1'b0;
    w0 = wb_cnt;
    set_load(32'h1E0, 14, 1);
    i_ld_valid = 1'b1;
    wait_acc("t4b_accept", 1'b0);
    i_ld_valid = 1'b0;
    i_kill = 1'b1;
    wb_q.delete();
    step();
    i_kill = 1'b0;
    check("t4b_req_dropped", {o_dc_req, o_busy}, 2'b00);
    gnt_en = 1'b1;
    repeat (4) step();
    check("t4b_no_wb", wb_cnt, w0);

    // 5: store with delayed grant; kill must not disturb it
    gnt_en = 1'b0;
    w0 = st_done_cnt;
    i_st_addr = 32'h40; i_st_data = 32'h55; i_st_idx = 2'd1;
    i_st_valid = 1'b1;
    wait_acc("t5_accept", 1'b1);
    i_st_valid = 1'b0;
    i_kill = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("t5_req_we", {o_dc_req, o_dc_we}, 2'b11);
      check("t5_addr", o_dc_addr, 32'h40);
      check("t5_wdata", o_dc_wdata, 32'h55);
      step();
    end
    gnt_en = 1'b1;
    wait_idle("t5_idle");
    i_kill = 1'b0;
    step();
    check("t5_done_count", st_done_cnt, w0 + 1);
    check("t5_cache_written", cmem[32'h40], 32'h55);

    // 6: reset while in LD_REQ
    gnt_en = 1'b0;
    set_load(32'h300, 3, 0);
    i_ld_valid = 1'b1;
    wait_acc("t6_accept", 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {o_dc_req, o_busy, o_ld_ready, o_st_ready, o_wb_valid, o_st_done}, '0);
    check("t6_rst_addr", o_dc_addr, '0);
    check("t6_rst_regs", {o_wb_rd, o_wb_laq, o_sdq_raddr, o_st_saq}, '0);
    wb_q.delete();
    step();
    step();
    n0 = ld_acc_cnt;
    rst = 1'b0;
    gnt_en = 1'b1;
    #3;
    check("t6_ready_after_rst", o_ld_ready, 1'b1);
    step();
    i_ld_valid = 1'b0;
    check("t6_accept_count", ld_acc_cnt, n0 + 1);
    wait_idle("t6_idle");
    repeat (3) step();

    check("wb_q_empty", wb_q.size(), 0);
    check("st_q_empty", st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsq_dcache_sched.md
Name: lsq_dcache_sched

Overview:
Scheduler sharing the single data-cache port between load issue (LAQ side) and committed-store drain (SAQ/SDQ side) in the AGU/LSU.
- Loads whose address hits an older store, as flagged by the address comparator in the same cycle, are served from the SDQ without touching the cache.
- Sequences one memory operation at a time.
- Returns load writebacks to the register file and store completions to the SAQ.

Parameters:
WIDTH_SAQ, 2, log2 of SAQ/SDQ depth
WIDTH_LAQ, 2, log2 of LAQ depth
WIDTH_REG, 7, physical register index width
WIDTH_ADDR, 32, address width
WIDTH_DATA, 32, data width
STARVE_MAX, 4, consecutive load grants allowed while a store waits

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
i_ld_valid  in  1  load candidate present
o_ld_ready  out  1  load accepted this cycle
i_ld_addr  in  WIDTH_ADDR  load address
i_ld_rd  in  WIDTH_REG  load destination register
i_ld_idx  in  WIDTH_LAQ  LAQ entry of load
i_fwd_hit  in  1  comparator: older store matches i_ld_addr
i_fwd_sdq  in  WIDTH_SAQ  SDQ entry holding forwarding data
i_st_valid  in  1  committed store at SAQ head
o_st_ready  out  1  store accepted this cycle
i_st_addr  in  WIDTH_ADDR  store address
i_st_data  in  WIDTH_DATA  store data
i_st_idx  in  WIDTH_SAQ  SAQ entry of store
i_saq_full  in  1  SAQ full, forces store priority
o_sdq_raddr  out  WIDTH_SAQ  SDQ read address (synchronous read, data next cycle)
i_sdq_rdata  in  WIDTH_DATA  SDQ read data
o_dc_req  out  1  cache request
o_dc_we  out  1  1 = write
o_dc_addr  out  WIDTH_ADDR  cache address
o_dc_wdata  out  WIDTH_DATA  cache write data
i_dc_gnt  in  1  cache accepted request
i_dc_rvalid  in  1  cache response (load data or write ack)
i_dc_rdata  in  WIDTH_DATA  cache read data
i_kill  in  1  pipeline flush, kills in-flight load
o_wb_valid  out  1  load writeback pulse
o_wb_rd  out  WIDTH_REG  writeback register
o_wb_data  out  WIDTH_DATA  writeback data
o_wb_laq  out  WIDTH_LAQ  LAQ entry completed
o_st_done  out  1  store complete pulse
o_st_saq  out  WIDTH_SAQ  SAQ entry completed
o_busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State IDLE; starve counter 0.
  - All outputs 0, including latched addr/data/rd/idx registers.
- States:
  - IDLE, LD_REQ, LD_WAIT, FWD, ST_REQ, ST_WAIT, DRAIN.
  - o_ld_ready and o_st_ready are asserted only in IDLE, at most one per cycle.
- Arbitration in IDLE:
  - Store wins if i_st_valid and (i_saq_full, or starve counter == STARVE_MAX, or !i_ld_valid).
  - Otherwise a load wins if i_ld_valid and !i_kill.
  - Accepting a load with i_st_valid high increments the starve counter, saturating at STARVE_MAX.
  - Accepting a store clears the counter.
- Load accept:
  - Latch addr, rd, idx.
  - If i_fwd_hit: drive o_sdq_raddr = i_fwd_sdq and go to FWD.
  - Else go to LD_REQ.
- FWD: next cycle, o_wb_valid = 1 with o_wb_data = i_sdq_rdata; go to IDLE. Forward latency is 2 cycles from accept to writeback.
- LD_REQ:
  - o_dc_req = 1, o_dc_we = 0, o_dc_addr held stable until i_dc_gnt.
  - On gnt, go to LD_WAIT.
- LD_WAIT: on i_dc_rvalid, o_wb_valid pulse with i_dc_rdata; go to IDLE.
- Store accept: latch addr, data, idx; go to ST_REQ.
- ST_REQ: o_dc_req = 1, o_dc_we = 1, addr/wdata stable; on gnt, go to ST_WAIT.
- ST_WAIT: on i_dc_rvalid, o_st_done pulse with o_st_saq; go to IDLE.
- Outputs o_wb_* and o_st_* are registered and valid for exactly one cycle.
- Kill:
  - In IDLE: blocks load acceptance that cycle.
  - In LD_REQ before gnt: drop request, go to IDLE, no writeback.
  - In LD_REQ coincident with gnt: go to DRAIN.
  - In LD_WAIT: go to DRAIN.
  - In FWD: suppress writeback, go to IDLE.
  - DRAIN swallows the next i_dc_rvalid without writeback, then goes to IDLE.
  - Kill never affects ST_REQ or ST_WAIT; committed stores always complete.
  - rvalid coincident with kill in LD_WAIT: writeback suppressed, go to IDLE directly.
- i_dc_rvalid while in IDLE, LD_REQ, FWD or ST_REQ is ignored.
- rst mid-operation: immediate return to IDLE. Outstanding cache responses are the cache's responsibility; the cache is reset on the same rst.

Decomposition:
- Shared package: state encoding constants, STARVE_MAX default.
- One sub-module, lsq_starve_ctr: saturating counter with inc/clr/at_max.

Test Plan:
1. Load only, no hit, addr 0x100, rd 5, idx 2. Gnt in the same cycle as req; rvalid 2 cycles later with data 0xDEADBEEF. Expected: o_wb_valid once, rd 5, laq 2, data 0xDEADBEEF.
2. Load with i_fwd_hit = 1, sdq 3; SDQ returns 0x1234. Expected: o_dc_req never high; o_sdq_raddr = 3; writeback 0x1234 exactly 2 cycles after accept.
3. Loads and stores valid continuously, STARVE_MAX = 4. Expected: grant order L, L, L, L, S, repeating. With i_saq_full = 1, a store is granted immediately.
4. i_kill asserted in LD_WAIT, then rvalid 3 cycles later with data 0xAA. Expected: no o_wb_valid; next load is accepted only after the drained response.
5. Store addr 0x40, data 0x55, idx 1, gnt held low 3 cycles. Expected: o_dc_we = 1, addr/wdata stable throughout; o_st_done with saq 1 after rvalid; i_kill mid-store has no effect.
6. rst asserted while in LD_REQ. Expected: all outputs 0 asynchronously; state IDLE; o_ld_ready = 1 on the first cycle after rst deasserts with i_ld_valid high.
